// File: rtl/pipe_flow_pkg.sv
// Shared types and sizing helpers for the pipe_flow_ctrl block.
package pipe_flow_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  // Width needed to hold an in-flight count of 0..latency inclusive.
  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/stall_pipe.sv
// LATENCY-deep {valid, data} register pipeline with one shared enable.
// Bubbles travel with the data; nothing is collapsed.
module stall_pipe #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0][WIDTH-1:0] dat_q, dat_d;

  // Shift every stage by one when enabled, otherwise hold everything.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d[0] = in_vld;
      dat_d[0] = in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Stage registers; reset drops every in-flight item at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld  = vld_q[LATENCY-1];
  assign out_data = dat_q[LATENCY-1];

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Flow control around a fixed-latency stallable pipeline: global enable from
// downstream back-pressure, in-flight counter, and drain-style flush FSM.
// Optional PIPE_FLOW_CTRL_STATS_EN adds saturating stall/accept counters.
module pipe_flow_ctrl
  import pipe_flow_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          flush,
  output logic                          flush_done,
  output logic [cnt_width(LATENCY)-1:0] count,
  output logic                          busy
`ifdef PIPE_FLOW_CTRL_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   accepted
`endif
);

  localparam int CW = cnt_width(LATENCY);

  if (LATENCY < 1) begin : g_bad_latency
    $error("pipe_flow_ctrl: LATENCY must be >= 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            flush_done_q, flush_done_d;
  logic            en, hs_in, hs_out;

  // A stalled last stage freezes the whole pipe; input is refused while draining.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && (state_q != FLUSH);
  assign hs_in    = in_valid && in_ready;
  assign hs_out   = out_valid && out_ready;

  stall_pipe #(.LATENCY(LATENCY), .WIDTH(WIDTH)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_vld   (hs_in),
    .in_data  (in_data),
    .out_vld  (out_valid),
    .out_data (out_data)
  );

  // In-flight count and FSM next state; flush_done is registered so it lands
  // in the first IDLE cycle after a drain.
  always_comb begin
    count_d      = count_q;
    state_d      = state_q;
    flush_done_d = 1'b0;
    if (hs_in && !hs_out)      count_d = count_q + CW'(1);
    else if (!hs_in && hs_out) count_d = count_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        if (flush)      state_d = FLUSH;
        else if (hs_in) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (flush)               state_d = FLUSH;
        else if (count_d == '0)  state_d = IDLE;
      end
      FLUSH: begin
        // Repeated flush requests here are deliberately ignored.
        if (count_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign count      = count_q;
  assign flush_done = flush_done_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(LATENCY));

`ifdef PIPE_FLOW_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d, acc_q, acc_d;

  // Saturating counters for back-pressure cycles and accepted items.
  always_comb begin
    stall_d = stall_q;
    acc_d   = acc_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (hs_in && (acc_q != '1))                     acc_d   = acc_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      acc_q   <= '0;
    end else begin
      stall_q <= stall_d;
      acc_q   <= acc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign accepted     = acc_q;
`endif

endmodule
